dot_product_pipe: RTL and testbench
===================================

Name: dot_product_pipe

Overview:
- Pipelined signed dot-product engine that consumes one row of A (inputData) and one row of B-transpose (weightData) per cycle.
- Returns one element of C, tagged with its (batch, output-feature) position, a fixed number of cycles later.
- Sits directly downstream of matrix_mult's read-address stage.
- Its result/tag stream feeds the row assembly that drives outputData/outputAddr/outputWrEn.
- Full throughput: one dot product accepted per cycle when not stalled.

Parameters:
- INPUT_FEATURES, 4, N: elements per row.
- LOG_INPUT_FEATURES, 2, ceil(log2(N)); number of adder-tree levels.
- INPUT_WIDTH, 4, bits per A element, signed two's complement.
- WEIGHT_WIDTH, 8, bits per B element, signed two's complement.
- OUTPUT_WIDTH, 16, bits of the result.
- TAG_WIDTH, 6, passthrough tag width; matrix_mult packs {batch index, o index}.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
- advance  in  1  pipeline enable; when low, every pipeline register holds.
- in_valid  in  1  inputs are valid this cycle.
- inputData  in  INPUT_FEATURES*INPUT_WIDTH  A row; element k at bits [k*INPUT_WIDTH +: INPUT_WIDTH].
- weightData  in  INPUT_FEATURES*WEIGHT_WIDTH  B-transpose row; same packing as inputData.
- in_tag  in  TAG_WIDTH  position tag carried alongside the data.
- out_valid  out  1  result valid.
- out_data  out  OUTPUT_WIDTH  dot product, signed, saturated.
- out_tag  out  TAG_WIDTH  tag of the result.
- out_sat  out  1  the result was clipped by saturation.

Behaviour:
- Reset: when rst=0 at a clock edge, all valid bits, out_data, out_tag and out_sat clear to 0. Data registers inside the pipe are also cleared. Reset overrides advance.
- Stage 0, multiply: registers INPUT_FEATURES signed products, each INPUT_WIDTH+WEIGHT_WIDTH bits wide.
  - If N is below 2^LOG_INPUT_FEATURES, the missing lanes are zero.
- Stages 1..LOG_INPUT_FEATURES, adder tree: each level is a registered pairwise signed add and grows the width by 1 bit.
  - Full width after the tree: PW = INPUT_WIDTH+WEIGHT_WIDTH+LOG_INPUT_FEATURES (14 at defaults).
- Final stage, output register:
  - If PW <= OUTPUT_WIDTH: sign-extend the sum.
  - Otherwise clamp to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1] and set out_sat=1 when clamping occurred.
- Latency: L = LOG_INPUT_FEATURES+2 advancing cycles (4 at defaults). With advance held at 1, a sample accepted at edge t appears on the outputs after edge t+L-1, i.e. L cycles after it is presented.
- Valid/tag pipeline: a shift register of L stages carries in_valid and in_tag in lockstep with the data.
  - out_valid=0 bubbles propagate; data registers may update on bubbles, but out_data is don't-care whenever out_valid=0.
- Stall: with advance=0, all stages, including the out_* registers, hold their values. A held out_valid=1 stays asserted; the consumer must not count it twice.
  - in_valid while advance=0 is ignored; the upstream stage must hold its request.
- Back-to-back: consecutive in_valid cycles produce consecutive out_valid cycles in the same order, with no gaps.
- Reset mid-operation: in-flight results are discarded. out_valid=0 from the first edge with rst=0 until L advancing cycles after the first new accepted input.
- Arithmetic is fully signed; there is no rounding. The most negative input times the most negative weight must not wrap inside the product width.

Decomposition:
- Shared package mm_pkg holds:
  - dimension defaults (M, N, O and their logs);
  - the element widths;
  - TAG_WIDTH and the tag field layout, {batch, o};
  - a constant function for the product and sum widths;
  - the element-slicing helper.
- One natural sub-module: dp_adder_level, a single registered pairwise-add level parameterised by lane count and input width. dot_product_pipe instantiates it LOG_INPUT_FEATURES times in a generate loop; multiply, valid/tag shift and saturation stay in the top.

Test Plan:
- Basic: A=[1,2,3,4], B=[1,1,1,1], tag=5, advance=1 -> after 4 cycles out_valid=1, out_data=10, out_tag=5, out_sat=0; out_valid=0 otherwise.
- Signed extremes: A=[-8,-8,-8,-8], B=[-128,-128,-128,-128] -> out_data=4096. A=[7,7,7,7], B=[-128,...] -> out_data=-3584, sign-extended to 16'hF200.
- Saturation with OUTPUT_WIDTH=12: the 4096 case -> out_data=2047, out_sat=1. The -3584 case -> out_data=-2048, out_sat=1.
- Streaming: 8 consecutive inputs with tags 0..7, A=[k,0,0,0], B=[1,0,0,0] -> 8 consecutive out_valid cycles with data 0..7 and tags 0..7 in order.
- Stall: advance=0 for 3 cycles mid-stream -> outputs frozen for those cycles, then the stream resumes with no loss or duplicate tags and total latency extended by 3.
- Reset: rst=0 for 1 cycle while 3 results are in flight -> out_valid=0 from the next cycle; none of the 3 tags ever appear; a new input after reset appears 4 cycles later.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix_mult datapath: dimension defaults,
// element widths, tag layout and small width/slicing helpers.
package mm_pkg;

  // Dimension defaults: A is M x N, B is N x O, C is M x O.
  localparam int unsigned DefM    = 8;
  localparam int unsigned DefLogM = 3;
  localparam int unsigned DefN    = 4;
  localparam int unsigned DefLogN = 2;
  localparam int unsigned DefO    = 8;
  localparam int unsigned DefLogO = 3;

  // Element widths, all signed two's complement.
  localparam int unsigned DefInputWidth  = 4;
  localparam int unsigned DefWeightWidth = 8;
  localparam int unsigned DefOutputWidth = 16;

  // Tag carried alongside each dot product: {batch index, output-feature index}.
  localparam int unsigned DefTagWidth = DefLogM + DefLogO;

  typedef struct packed {
    logic [DefLogM-1:0] batch;
    logic [DefLogO-1:0] o;
  } tag_t;

  // Widest packed row the slicing helper accepts.
  localparam int unsigned ElemBusW = 256;

  // Full-precision width of one element product.
  function automatic int unsigned prod_width(input int unsigned in_w, input int unsigned wt_w);
    return in_w + wt_w;
  endfunction

  // Full-precision width after a log_n-level pairwise adder tree.
  function automatic int unsigned sum_width(input int unsigned in_w, input int unsigned wt_w,
                                            input int unsigned log_n);
    return in_w + wt_w + log_n;
  endfunction

  // Element k of a packed row with w-bit elements, sign-extended to 32 bits.
  function automatic logic signed [31:0] elem_at(input logic [ElemBusW-1:0] bus,
                                                 input int unsigned k, input int unsigned w);
    logic [31:0] raw;
    raw = 32'(bus >> (k * w));
    return $signed(raw << (32 - w)) >>> (32 - w);
  endfunction

endpackage

// File: rtl/dot_product_pipe_if.sv
// Request/result bundle between the read-address stage, the dot-product pipe
// and the row assembly. The producer/consumer side uses master, the pipe slave.
interface dot_product_pipe_if #(
  parameter int unsigned INPUT_FEATURES = mm_pkg::DefN,
  parameter int unsigned INPUT_WIDTH    = mm_pkg::DefInputWidth,
  parameter int unsigned WEIGHT_WIDTH   = mm_pkg::DefWeightWidth,
  parameter int unsigned OUTPUT_WIDTH   = mm_pkg::DefOutputWidth,
  parameter int unsigned TAG_WIDTH      = mm_pkg::DefTagWidth
);

  logic                                   advance;
  logic                                   in_valid;
  logic [INPUT_FEATURES*INPUT_WIDTH-1:0]  inputData;
  logic [INPUT_FEATURES*WEIGHT_WIDTH-1:0] weightData;
  logic [TAG_WIDTH-1:0]                   in_tag;
  logic                                   out_valid;
  logic [OUTPUT_WIDTH-1:0]                out_data;
  logic [TAG_WIDTH-1:0]                   out_tag;
  logic                                   out_sat;

  modport master (
    output advance, in_valid, inputData, weightData, in_tag,
    input  out_valid, out_data, out_tag, out_sat
  );

  modport slave (
    input  advance, in_valid, inputData, weightData, in_tag,
    output out_valid, out_data, out_tag, out_sat
  );

endinterface

// File: rtl/dp_adder_level.sv
// One registered level of the dot-product adder tree: adds adjacent lane
// pairs with one bit of growth and holds while advance_i is low.
module dp_adder_level #(
  parameter int unsigned Lanes   = 2,
  parameter int unsigned InWidth = 12
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 advance_i,
  input  logic [Lanes*InWidth-1:0]             in_i,
  output logic [(Lanes/2)*(InWidth+1)-1:0]     out_o
);

  localparam int unsigned OutLanes = Lanes / 2;
  localparam int unsigned OutWidth = InWidth + 1;

  logic [OutLanes*OutWidth-1:0] sum_d, sum_q;

  // Pairwise signed add of lanes 2j and 2j+1.
  always_comb begin
    sum_d = '0;
    for (int unsigned j = 0; j < OutLanes; j++) begin
      sum_d[j*OutWidth +: OutWidth] = OutWidth'($signed(in_i[(2*j)*InWidth +: InWidth]))
                                    + OutWidth'($signed(in_i[(2*j+1)*InWidth +: InWidth]));
    end
  end

  // Level register: synchronous clear, hold on stall.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sum_q <= '0;
    end else if (advance_i) begin
      sum_q <= sum_d;
    end
  end

  assign out_o = sum_q;

endmodule

// File: rtl/dot_product_pipe.sv
// Pipelined signed dot product: multiply stage, LOG_INPUT_FEATURES adder
// levels and a saturating output register, with the valid/tag pair shifted
// alongside so each result leaves with its (batch, o) position.
module dot_product_pipe
  import mm_pkg::*;
#(
  parameter int unsigned INPUT_FEATURES     = DefN,
  parameter int unsigned LOG_INPUT_FEATURES = DefLogN,
  parameter int unsigned INPUT_WIDTH        = DefInputWidth,
  parameter int unsigned WEIGHT_WIDTH       = DefWeightWidth,
  parameter int unsigned OUTPUT_WIDTH       = DefOutputWidth,
  parameter int unsigned TAG_WIDTH          = DefTagWidth
) (
  input logic               clk,
  input logic               rst,
  dot_product_pipe_if.slave bus
);

  localparam int unsigned Lanes   = 1 << LOG_INPUT_FEATURES;
  localparam int unsigned ProdW   = prod_width(INPUT_WIDTH, WEIGHT_WIDTH);
  localparam int unsigned SumW    = sum_width(INPUT_WIDTH, WEIGHT_WIDTH, LOG_INPUT_FEATURES);
  localparam int unsigned Latency = LOG_INPUT_FEATURES + 2;

  // Bit offset of tree level lvl inside the flat tree vector; level 0 holds
  // the products, level LOG_INPUT_FEATURES the single final sum.
  function automatic int unsigned level_offset(input int unsigned lvl);
    int unsigned off;
    off = 0;
    for (int unsigned j = 0; j < lvl; j++) begin
      off += (Lanes >> j) * (ProdW + j);
    end
    return off;
  endfunction

  localparam int unsigned TreeW = level_offset(LOG_INPUT_FEATURES + 1);

  logic [Lanes*ProdW-1:0]  prod_d, prod_q;
  logic [TreeW-1:0]        tree;
  logic signed [SumW-1:0]  sum;
  logic [OUTPUT_WIDTH-1:0] sat_data;
  logic                    sat_flag;

  logic [Latency-1:0]      vld_d, vld_q;
  logic [TAG_WIDTH-1:0]    tag_d [Latency];
  logic [TAG_WIDTH-1:0]    tag_q [Latency];
  logic [OUTPUT_WIDTH-1:0] out_data_d, out_data_q;
  logic                    out_sat_d, out_sat_q;

  // Per-lane signed products; padding lanes beyond INPUT_FEATURES stay zero.
  // ProdW always holds (-2^(a-1)) * (-2^(b-1)) without wrapping.
  always_comb begin
    prod_d = '0;
    for (int unsigned k = 0; k < Lanes; k++) begin
      if (k < INPUT_FEATURES) begin
        prod_d[k*ProdW +: ProdW] =
          ProdW'(elem_at(ElemBusW'(bus.inputData), k, INPUT_WIDTH)
               * elem_at(ElemBusW'(bus.weightData), k, WEIGHT_WIDTH));
      end
    end
  end

  // Multiply stage register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prod_q <= '0;
    end else if (bus.advance) begin
      prod_q <= prod_d;
    end
  end

  assign tree[0 +: Lanes*ProdW] = prod_q;

  for (genvar i = 0; i < LOG_INPUT_FEATURES; i++) begin : g_level
    dp_adder_level #(
      .Lanes   (Lanes >> i),
      .InWidth (ProdW + i)
    ) u_level (
      .clk_i     (clk),
      .rst_ni    (rst),
      .advance_i (bus.advance),
      .in_i      (tree[level_offset(i) +: (Lanes >> i) * (ProdW + i)]),
      .out_o     (tree[level_offset(i + 1) +: (Lanes >> (i + 1)) * (ProdW + i + 1)])
    );
  end

  assign sum = $signed(tree[level_offset(LOG_INPUT_FEATURES) +: SumW]);

  if (SumW <= OUTPUT_WIDTH) begin : g_extend
    assign sat_data = OUTPUT_WIDTH'(sum);
    assign sat_flag = 1'b0;
  end else begin : g_clamp
    localparam logic signed [SumW-1:0] SatMax =
      {{(SumW - OUTPUT_WIDTH + 1){1'b0}}, {(OUTPUT_WIDTH - 1){1'b1}}};
    localparam logic signed [SumW-1:0] SatMin =
      {{(SumW - OUTPUT_WIDTH + 1){1'b1}}, {(OUTPUT_WIDTH - 1){1'b0}}};

    // Clamp the full-width sum into the signed output range.
    always_comb begin
      sat_flag = 1'b0;
      sat_data = sum[OUTPUT_WIDTH-1:0];
      if (sum > SatMax) begin
        sat_data = SatMax[OUTPUT_WIDTH-1:0];
        sat_flag = 1'b1;
      end else if (sum < SatMin) begin
        sat_data = SatMin[OUTPUT_WIDTH-1:0];
        sat_flag = 1'b1;
      end
    end
  end

  // Next state of the valid/tag shift register and the output register.
  always_comb begin
    vld_d      = {vld_q[Latency-2:0], bus.in_valid};
    tag_d[0]   = bus.in_tag;
    for (int unsigned i = 1; i < Latency; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    out_data_d = sat_data;
    out_sat_d  = sat_flag;
  end

  // Valid/tag shift and output register; reset beats advance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q      <= '0;
      tag_q      <= '{default: '0};
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else if (bus.advance) begin
      vld_q      <= vld_d;
      tag_q      <= tag_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign bus.out_valid = vld_q[Latency-1];
  assign bus.out_tag   = tag_q[Latency-1];
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_dot_product_pipe.sv
// Bench for dot_product_pipe: a 16-bit-output and a 12-bit-output instance
// share one stimulus stream and are checked against a latency-queue model.
module tb_dot_product_pipe;
  import mm_pkg::*;

  localparam int unsigned Lat = DefLogN + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dot_product_pipe_if if16 ();
  dot_product_pipe_if #(.OUTPUT_WIDTH(12)) if12 ();

  assign if12.advance    = if16.advance;
  assign if12.in_valid   = if16.in_valid;
  assign if12.inputData  = if16.inputData;
  assign if12.weightData = if16.weightData;
  assign if12.in_tag     = if16.in_tag;

  dot_product_pipe u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16)
  );

  dot_product_pipe #(.OUTPUT_WIDTH(12)) u_dut12 (
    .clk (clk),
    .rst (rst),
    .bus (if12)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int tag;
    int d16;
    int s16;
    int d12;
    int s12;
    int age;
  } item_t;

  item_t q[$];
  item_t exp_item;
  item_t new_item;
  logic  exp_valid = 1'b0;
  int    accepted  = 0;
  int    killed    = 0;
  int    seen      = 0;
  int    dot;
  logic  was_reset;
  logic  was_adv;

  function automatic int ref_dot(input logic [15:0] a, input logic [31:0] b);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      s += int'($signed(a[k*4 +: 4])) * int'($signed(b[k*8 +: 8]));
    end
    return s;
  endfunction

  function automatic int clamp(input int v, input int w);
    int hi;
    int lo;
    hi = (1 <<< (w - 1)) - 1;
    lo = -(1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference: every accepted row ages by one per advancing edge and is
  // presented once its age reaches the pipe latency; stalls freeze everything.
  always @(posedge clk) begin
    was_reset = !rst;
    was_adv   = if16.advance;
    if (!rst) begin
      killed   += q.size();
      q.delete();
      exp_valid = 1'b0;
    end else if (if16.advance) begin
      foreach (q[i]) q[i].age++;
      if (if16.in_valid) begin
        dot          = ref_dot(if16.inputData, if16.weightData);
        new_item.tag = int'(if16.in_tag);
        new_item.d16 = clamp(dot, 16);
        new_item.s16 = (clamp(dot, 16) != dot) ? 1 : 0;
        new_item.d12 = clamp(dot, 12);
        new_item.s12 = (clamp(dot, 12) != dot) ? 1 : 0;
        new_item.age = 1;
        q.push_back(new_item);
        accepted++;
      end
      exp_valid = 1'b0;
      if (q.size() > 0 && q[0].age == Lat) begin
        exp_item  = q.pop_front();
        exp_valid = 1'b1;
      end
    end
    #1;
    check_eq("valid16", {31'd0, if16.out_valid}, {31'd0, exp_valid});
    check_eq("valid12", {31'd0, if12.out_valid}, {31'd0, exp_valid});
    if (was_reset) begin
      check_eq("rst_data16", {16'd0, if16.out_data}, 32'd0);
      check_eq("rst_tag16", {26'd0, if16.out_tag}, 32'd0);
      check_eq("rst_sat16", {31'd0, if16.out_sat}, 32'd0);
      check_eq("rst_data12", {20'd0, if12.out_data}, 32'd0);
    end else if (exp_valid) begin
      check_eq("tag16", {26'd0, if16.out_tag}, exp_item.tag & 32'h3F);
      check_eq("data16", {16'd0, if16.out_data}, exp_item.d16 & 32'hFFFF);
      check_eq("sat16", {31'd0, if16.out_sat}, exp_item.s16);
      check_eq("tag12", {26'd0, if12.out_tag}, exp_item.tag & 32'h3F);
      check_eq("data12", {20'd0, if12.out_data}, exp_item.d12 & 32'hFFF);
      check_eq("sat12", {31'd0, if12.out_sat}, exp_item.s12);
    end
    // Consumer view: a held result counts once, on the edge that produced it.
    if (!was_reset && was_adv && if16.out_valid) seen++;
  end

  task automatic drive(input logic r, input logic adv, input logic v, input logic [15:0] a,
                       input logic [31:0] b, input logic [5:0] t);
    @(negedge clk);
    rst             = r;
    if16.advance    = adv;
    if16.in_valid   = v;
    if16.inputData  = a;
    if16.weightData = b;
    if16.in_tag     = t;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 16'h0, 32'h0, 6'd0);
  endtask

  initial begin
    if16.advance    = 1'b0;
    if16.in_valid   = 1'b0;
    if16.inputData  = '0;
    if16.weightData = '0;
    if16.in_tag     = '0;

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 16'h0, 32'h0, 6'd0);
    idle(2);

    // A=[1,2,3,4], B=[1,1,1,1] -> 10
    drive(1'b1, 1'b1, 1'b1, 16'h4321, 32'h01010101, 6'd5);
    idle(6);

    // Signed extremes: 4096 (clips at 12 bits) and -3584 (F200 / clips to -2048)
    drive(1'b1, 1'b1, 1'b1, 16'h8888, 32'h80808080, 6'd1);
    drive(1'b1, 1'b1, 1'b1, 16'h7777, 32'h80808080, 6'd2);
    idle(6);

    // Back-to-back stream A=[k,0,0,0], B=[1,0,0,0]
    for (int k = 0; k < 8; k++) drive(1'b1, 1'b1, 1'b1, 16'(k), 32'h1, 6'(k));
    idle(6);

    // Stream with a 3-cycle stall; the held request stays on the inputs
    for (int k = 8; k < 16; k++) begin
      if (k == 11) begin
        for (int s = 0; s < 3; s++) drive(1'b1, 1'b0, 1'b1, 16'(k), 32'h03, 6'(k));
      end
      drive(1'b1, 1'b1, 1'b1, 16'(k), 32'h03, 6'(k));
    end
    idle(6);

    // Reset with three results in flight, then a fresh input
    drive(1'b1, 1'b1, 1'b1, 16'h1111, 32'h01010101, 6'd20);
    drive(1'b1, 1'b1, 1'b1, 16'h2222, 32'h01010101, 6'd21);
    drive(1'b1, 1'b1, 1'b1, 16'h3333, 32'h01010101, 6'd22);
    drive(1'b0, 1'b1, 1'b0, 16'h0, 32'h0, 6'd0);
    drive(1'b1, 1'b1, 1'b1, 16'h0005, 32'h00000002, 6'd23);
    idle(6);

    // Random traffic with stalls and occasional resets
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(99) != 0), ($urandom_range(9) < 8), 1'($urandom_range(1)),
            16'($urandom), $urandom, 6'($urandom));
    end
    idle(10);

    @(negedge clk);
    check_eq("drain_queue", q.size(), 32'd0);
    check_eq("drain_count", seen, accepted - killed);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
